// File: rtl/cpu19_ctrl_seq.sv
// Fetch/decode/execute control sequencer for the 19-bit CPU.
// Latches instructions into ir, drives decoder select and register-file fields, and times out stalled executes.
module cpu19_ctrl_seq #(
   parameter int unsigned PC_W         = 8,
   parameter int unsigned EXEC_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [18:0]     instr_in,
   input  logic            instr_valid,
   input  logic            exec_done,
   output logic            fetch_req,
   output logic [PC_W-1:0] pc,
   output logic [3:0]      select,
   output logic [3:0]      rd_addr,
   output logic [3:0]      rs1_addr,
   output logic [3:0]      rs2_addr,
   output logic [6:0]      imm7,
   output logic            exec_start,
   output logic            reg_we,
   output logic            halted,
   output logic            fault
);

   localparam int unsigned CNT_W = $clog2(EXEC_TIMEOUT + 1);
   localparam int unsigned JMP_W = (PC_W > 7) ? PC_W : 7;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t            state, state_nxt;
   logic [18:0]       ir, ir_nxt;
   logic [PC_W-1:0]   pc_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [3:0]        select_nxt, rd_nxt, rs1_nxt, rs2_nxt;
   logic [6:0]        imm_nxt;
   logic              fault_nxt, exec_start_nxt;
   logic [JMP_W-1:0]  jmp_ext;

   // Zero-extend (or truncate) imm7 to the PC width for JMP.
   assign jmp_ext = JMP_W'(ir[6:0]);

   // Next-state and next-value logic.
   always_comb begin
      state_nxt      = state;
      ir_nxt         = ir;
      pc_nxt         = pc;
      cnt_nxt        = cnt;
      select_nxt     = select;
      rd_nxt         = rd_addr;
      rs1_nxt        = rs1_addr;
      rs2_nxt        = rs2_addr;
      imm_nxt        = imm7;
      fault_nxt      = fault;
      exec_start_nxt = 1'b0;

      case (state)
         S_FETCH: begin
            if (instr_valid) begin
               ir_nxt    = instr_in;
               pc_nxt    = pc + PC_W'(1);
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            select_nxt = ir[18:15];
            rd_nxt     = ir[14:11];
            rs1_nxt    = ir[10:7];
            rs2_nxt    = ir[6:3];
            imm_nxt    = ir[6:0];
            case (ir[18:15])
               OP_NOP:  state_nxt = S_FETCH;
               OP_JMP: begin
                  pc_nxt    = jmp_ext[PC_W-1:0];
                  state_nxt = S_FETCH;
               end
               OP_HALT: state_nxt = S_HALT;
               default: begin
                  state_nxt      = S_EXECUTE;
                  exec_start_nxt = 1'b1;
               end
            endcase
         end
         S_EXECUTE: begin
            cnt_nxt = cnt + CNT_W'(1);
            // Done takes precedence over a timeout landing in the same cycle.
            if (exec_done) begin
               cnt_nxt   = '0;
               state_nxt = S_WRITEBACK;
            end else if (cnt == CNT_W'(EXEC_TIMEOUT - 1)) begin
               cnt_nxt   = '0;
               fault_nxt = 1'b1;
               state_nxt = S_HALT;
            end
         end
         S_WRITEBACK: state_nxt = S_FETCH;
         S_HALT:      state_nxt = S_HALT;
         default:     state_nxt = S_FETCH;
      endcase
   end

   // State and output registers; status outputs track the registered next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_FETCH;
         ir         <= '0;
         pc         <= '0;
         cnt        <= '0;
         select     <= '0;
         rd_addr    <= '0;
         rs1_addr   <= '0;
         rs2_addr   <= '0;
         imm7       <= '0;
         fault      <= 1'b0;
         exec_start <= 1'b0;
         reg_we     <= 1'b0;
         halted     <= 1'b0;
         fetch_req  <= 1'b1;
      end else begin
         state      <= state_nxt;
         ir         <= ir_nxt;
         pc         <= pc_nxt;
         cnt        <= cnt_nxt;
         select     <= select_nxt;
         rd_addr    <= rd_nxt;
         rs1_addr   <= rs1_nxt;
         rs2_addr   <= rs2_nxt;
         imm7       <= imm_nxt;
         fault      <= fault_nxt;
         exec_start <= exec_start_nxt;
         reg_we     <= (state_nxt == S_WRITEBACK);
         halted     <= (state_nxt == S_HALT);
         fetch_req  <= (state_nxt == S_FETCH);
      end
   end

endmodule
